mic_buffer_mc: RTL and testbench

MIC_BUFFER_MC -- requirements
Module: mic_buffer_mc

---
 rtl/mic_buffer_mc.sv | 192 +++++++++++++++++++
 tb/tb_mic_buffer_mc.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mic_buffer_mc.sv
`default_nettype none
// ============================================================================
// Module   : mic_buffer_mc
// Purpose  : Capture buffer for interleaved multi-channel audio samples.
//            A small FSM (IDLE/SYNC/RUN) aligns capture to channel 0. Samples
//            are stored in a first-word fall-through FIFO. The FIFO provides
//            a watermark pulse and a sticky overflow flag, and its overflow
//            policy (drop new sample or overwrite oldest) is selectable.
// Ports    : clk, rst_n (sync, active-low)
//            in_enable          - capture enable; a rising edge flushes the FIFO
//            audio/audio_ch/irq - incoming sample, its channel, valid strobe
//            out_read           - pop head entry
//            out_audio/out_ch   - head entry (holds last value when empty)
//            out_irq            - one-cycle watermark-crossing pulse
//            enable             - in_enable delayed one cycle
//            level/full/empty   - FIFO occupancy
//            overflow/clr_ovf   - sticky overflow flag and its clear
// Revision : 1.0 - initial release
// ============================================================================
module mic_buffer_mc #(
    parameter int DATA_W       = 24,
    parameter int DEPTH        = 16,
    parameter int CHANNELS     = 2,
    parameter int WATERMARK    = 8,
    parameter int OVF_DROP_OLD = 0,
    parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int LVL_W        = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_enable,
    input  logic [DATA_W-1:0] audio,
    input  logic [CH_W-1:0]   audio_ch,
    input  logic              irq,
    input  logic              out_read,
    output logic [DATA_W-1:0] out_audio,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_irq,
    output logic              enable,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_ENT_W = CH_W + DATA_W;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SYNC = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;

    localparam logic [LVL_W-1:0] c_LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] c_LVL_WM   = LVL_W'(WATERMARK);
    localparam logic [LVL_W-1:0] c_LVL_WM_M = LVL_W'(WATERMARK - 1);

    logic [1:0]         r_state;
    logic               r_en_d;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic               r_ovf;
    logic               r_out_irq;
    logic [c_ENT_W-1:0] r_hold;
    logic [c_ENT_W-1:0] r_mem [DEPTH];

    logic               w_rise;
    logic               w_full;
    logic               w_empty;
    logic               w_sync_ok;
    logic               w_wr_acc;
    logic               w_rd;
    logic               w_push;
    logic               w_pop;
    logic               w_ovf_evt;
    logic [LVL_W-1:0]   w_level_nxt;
    logic [c_ENT_W-1:0] w_head;

    assign w_rise    = in_enable && !r_en_d;
    assign w_full    = (r_level == c_LVL_FULL);
    assign w_empty   = (r_level == '0);
    // With a single channel every sample is a frame start.
    assign w_sync_ok = (CHANNELS == 1) || (audio_ch == '0);
    assign w_wr_acc  = irq && ((r_state == c_ST_RUN) ||
                               ((r_state == c_ST_SYNC) && w_sync_ok));
    assign w_rd      = out_read && !w_empty;
    assign w_head    = r_mem[r_rd_ptr];

    // Push/pop decision including both overflow policies.
    always_comb begin
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_ovf_evt   = 1'b0;
        w_level_nxt = r_level;
        if (w_wr_acc && !w_full) begin
            w_push = 1'b1;
            w_pop  = w_rd;
            if (!w_rd) begin
                w_level_nxt = r_level + LVL_W'(1);
            end
        end else if (w_wr_acc) begin
            if (OVF_DROP_OLD != 0) begin
                // Oldest entry makes room; a coincident read is that discard.
                w_push    = 1'b1;
                w_pop     = 1'b1;
                w_ovf_evt = !out_read;
            end else begin
                w_pop     = w_rd;
                w_ovf_evt = 1'b1;
                if (w_rd) begin
                    w_level_nxt = r_level - LVL_W'(1);
                end
            end
        end else if (w_rd) begin
            w_pop       = 1'b1;
            w_level_nxt = r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_en_d    <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_ovf     <= 1'b0;
            r_out_irq <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_en_d <= in_enable;

            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end

            // Last head value is kept so outputs are stable once drained.
            if (!w_empty) begin
                r_hold <= w_head;
            end

            if (w_rise) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_level   <= '0;
                r_out_irq <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                r_level   <= w_level_nxt;
                // Level moves by at most one per cycle, so an upward step onto
                // the watermark can only recur after dropping below it.
                r_out_irq <= (r_level == c_LVL_WM_M) && (w_level_nxt == c_LVL_WM);
            end

            if (!in_enable) begin
                r_state <= c_ST_IDLE;
            end else begin
                case (r_state)
                    c_ST_IDLE: if (w_rise) r_state <= c_ST_SYNC;
                    c_ST_SYNC: if (w_wr_acc) r_state <= c_ST_RUN;
                    c_ST_RUN:  r_state <= c_ST_RUN;
                    default:   r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (rst_n && w_push && !w_rise) begin
            r_mem[r_wr_ptr] <= {audio_ch, audio};
        end
    end

    assign {out_ch, out_audio} = w_empty ? r_hold : w_head;
    assign out_irq  = r_out_irq;
    assign enable   = r_en_d;
    assign level    = r_level;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mic_buffer_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_mic_buffer_mc
// Purpose  : Self-checking bench for mic_buffer_mc. Two instances share one
//            stimulus stream, one per overflow policy. A queue-based reference
//            model per instance holds the expected FIFO contents; entries are
//            pushed when a write is driven and popped/compared as the DUT
//            delivers them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mic_buffer_mc;

    localparam int c_DW    = 24;
    localparam int c_DEPTH = 16;
    localparam int c_CHN   = 2;
    localparam int c_WM    = 8;
    localparam int c_CHW   = 1;
    localparam int c_LW    = 5;
    localparam int c_EW    = c_CHW + c_DW;

    localparam int c_IDLE = 0;
    localparam int c_SYNC = 1;
    localparam int c_RUN  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              in_enable;
    logic [c_DW-1:0]   audio;
    logic [c_CHW-1:0]  audio_ch;
    logic              irq;
    logic              out_read;
    logic              clr_ovf;

    logic [c_DW-1:0]   out_audio [2];
    logic [c_CHW-1:0]  out_ch    [2];
    logic              out_irq   [2];
    logic              enable    [2];
    logic [c_LW-1:0]   level     [2];
    logic              full      [2];
    logic              empty     [2];
    logic              overflow  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mic_buffer_mc #(
            .DATA_W      (c_DW),
            .DEPTH       (c_DEPTH),
            .CHANNELS    (c_CHN),
            .WATERMARK   (c_WM),
            .OVF_DROP_OLD(g)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_enable(in_enable),
            .audio    (audio),
            .audio_ch (audio_ch),
            .irq      (irq),
            .out_read (out_read),
            .out_audio(out_audio[g]),
            .out_ch   (out_ch[g]),
            .out_irq  (out_irq[g]),
            .enable   (enable[g]),
            .level    (level[g]),
            .full     (full[g]),
            .empty    (empty[g]),
            .overflow (overflow[g]),
            .clr_ovf  (clr_ovf)
        );
    end

    // Reference model state
    logic [c_EW-1:0] mq [2][$];
    logic [c_EW-1:0] m_last [2];
    logic            m_ovf  [2];
    logic            m_irq  [2];
    logic            m_en_d;
    int              m_state;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_outputs();
        logic [c_EW-1:0] eh;
        for (int k = 0; k < 2; k++) begin
            eh = (mq[k].size() != 0) ? mq[k][0] : m_last[k];
            chk($sformatf("level%0d", k), 32'(level[k]), 32'(mq[k].size()));
            chk($sformatf("empty%0d", k), 32'(empty[k]), 32'(mq[k].size() == 0));
            chk($sformatf("full%0d", k), 32'(full[k]), 32'(mq[k].size() == c_DEPTH));
            chk($sformatf("head%0d", k), 32'({out_ch[k], out_audio[k]}), 32'(eh));
            chk($sformatf("ovf%0d", k), 32'(overflow[k]), 32'(m_ovf[k]));
            chk($sformatf("wmirq%0d", k), 32'(out_irq[k]), 32'(m_irq[k]));
            chk($sformatf("enable%0d", k), 32'(enable[k]), 32'(m_en_d));
        end
    endtask

    // One clock of stimulus; the model advances with the same inputs.
    task automatic step(input logic en, input logic ir, input logic ch,
                        input logic [c_DW-1:0] d, input logic rd, input logic clr);
        logic rise, wr, evt;
        int   old_n;
        rise = en && !m_en_d;
        wr   = ir && ((m_state == c_RUN) || ((m_state == c_SYNC) && (ch == 1'b0)));
        in_enable = en; irq = ir; audio_ch = ch; audio = d; out_read = rd; clr_ovf = clr;
        for (int k = 0; k < 2; k++) begin
            old_n = mq[k].size();
            evt   = 1'b0;
            if (old_n != 0) begin
                m_last[k] = mq[k][0];
                if (rd) begin
                    chk($sformatf("pop%0d", k), 32'({out_ch[k], out_audio[k]}), 32'(mq[k][0]));
                end
            end
            if (rise) begin
                mq[k].delete();
            end else if (wr && old_n < c_DEPTH) begin
                if (rd && old_n != 0) void'(mq[k].pop_front());
                mq[k].push_back({ch, d});
            end else if (wr) begin
                if (k == 0) begin
                    if (rd) void'(mq[k].pop_front());
                    evt = 1'b1;
                end else begin
                    void'(mq[k].pop_front());
                    mq[k].push_back({ch, d});
                    evt = !rd;
                end
            end else if (rd && old_n != 0) begin
                void'(mq[k].pop_front());
            end
            if (evt) m_ovf[k] = 1'b1;
            else if (clr) m_ovf[k] = 1'b0;
            m_irq[k] = (old_n == c_WM - 1) && (mq[k].size() == c_WM);
        end
        if (!en) m_state = c_IDLE;
        else if (m_state == c_IDLE) begin
            if (rise) m_state = c_SYNC;
        end else if (m_state == c_SYNC && wr) m_state = c_RUN;
        m_en_d = en;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input logic en);
        rst_n = 1'b0; in_enable = en; irq = 1'b0; out_read = 1'b0; clr_ovf = 1'b0;
        audio = '0; audio_ch = '0;
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            m_last[k] = '0; m_ovf[k] = 1'b0; m_irq[k] = 1'b0;
        end
        m_en_d = 1'b0; m_state = c_IDLE;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_outputs();
    endtask

    task automatic wr(input logic ch, input logic [c_DW-1:0] d);
        step(1'b1, 1'b1, ch, d, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        do_reset(1'b0);
        do_reset(1'b0);

        // Frame alignment: leading ch1 dropped in SYNC
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        wr(1'b1, 24'h000101);
        wr(1'b0, 24'h000200);
        wr(1'b1, 24'h000301);
        wr(1'b0, 24'h000400);
        chk("align_level", 32'(level[0]), 32'd3);

        // Re-enable flushes; irq in IDLE ignored; read while empty ignored
        wr(1'b1, 24'h000501);
        wr(1'b0, 24'h000600);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 24'h000777, 1'b0, 1'b0);
        chk("idle_irq_level", 32'(level[0]), 32'd5);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("flush_level", 32'(level[0]), 32'd0);
        rd();
        chk("rd_empty_level", 32'(level[0]), 32'd0);

        // Watermark pulse: still in SYNC so ch1 is dropped first
        wr(1'b1, 24'h000BAD);
        for (int i = 0; i < 8; i++) wr(1'(i), c_DW'(i + 16));
        chk("wm_first_pulse", 32'(out_irq[0]), 32'd1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        rd();
        wr(1'b0, 24'h000099);
        chk("wm_second_pulse", 32'(out_irq[0]), 32'd1);
        for (int i = 0; i < 8; i++) rd();

        // Fill, then overflow under both policies
        for (int i = 1; i <= 16; i++) wr(1'(i), c_DW'(i));
        wr(1'b0, 24'h0000AA);
        chk("drop_new_head", 32'(out_audio[0]), 32'h000001);
        chk("drop_old_head", 32'(out_audio[1]), 32'h000002);
        chk("drop_new_ovf", 32'(overflow[0]), 32'd1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow[0]), 32'd0);
        step(1'b1, 1'b1, 1'b1, 24'h0000BB, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 24'h0000CC, 1'b0, 1'b1);
        chk("ovf_beats_clr", 32'(overflow[1]), 32'd1);
        for (int i = 0; i < 17; i++) rd();

        // Reset with entries stored, enable held high across release
        for (int i = 0; i < 10; i++) wr(1'(i), c_DW'(i + 32'h300));
        chk("pre_reset_level", 32'(level[0]), 32'd10);
        do_reset(1'b1);
        wr(1'b0, 24'h000055);
        wr(1'b0, 24'h000056);
        wr(1'b1, 24'h000057);
        rd();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
